// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues sequential word fetches, buffers the returned
// instructions in order with their pc, and hands {pc, instr} to decode.
// Redirects flush queued entries and discard responses still in flight.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] LIMIT = (PW + 1)'(DEPTH);

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [PW-1:0] r_alloc;
  logic [PW-1:0] r_fill;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_drop;
  logic [31:0]   r_fetch_pc;

  logic [PW-1:0] w_outstanding;
  logic [PW-1:0] w_queued;
  logic [PW-1:0] w_occ;
  logic [PW:0]   w_credit;
  logic          w_req_fire;
  logic          w_rsp_fire;
  logic          w_rsp_take;
  logic          w_out_fire;
  logic          w_unused;

  // Pointer differences, credit usage and handshake qualifiers
  always_comb begin
    w_outstanding = r_alloc - r_fill;
    w_queued      = r_fill - r_head;
    w_occ         = r_alloc - r_head;
    // Responses owed to a flushed epoch still hold credit until they return.
    w_credit      = {1'b0, w_occ} + {1'b0, r_drop};
    req_valid     = !reset && !redirect_valid && (w_credit < LIMIT);
    req_addr      = r_fetch_pc;
    rsp_ready     = !reset;
    out_valid     = !reset && !redirect_valid && (w_queued != '0);
    out_pc        = reset ? '0 : r_pc[r_head[AW-1:0]];
    out_instr     = reset ? '0 : r_instr[r_head[AW-1:0]];
    w_req_fire    = req_valid && req_ready;
    w_rsp_fire    = rsp_valid && rsp_ready;
    // A response with nothing owed is a protocol error and is ignored.
    w_rsp_take    = w_rsp_fire && ((r_drop != '0) || (w_outstanding != '0));
    w_out_fire    = out_valid && out_ready;
    // Low address bits of a redirect target are forced to zero.
    w_unused      = ^redirect_pc[1:0];
  end

  // Fetch pc, queue pointers and drop counter; redirect overrides all other events
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_head     <= '0;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_head     <= r_alloc;
      r_fill     <= r_alloc;
      // Everything in flight is owed to the old epoch; a response taken this
      // cycle has already paid back one of those.
      r_drop     <= r_drop + w_outstanding - {{(PW-1){1'b0}}, w_rsp_take};
    end else begin
      if (w_req_fire) begin
        r_alloc    <= r_alloc + 1'b1;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_rsp_take) begin
        if (r_drop != '0) r_drop <= r_drop - 1'b1;
        else              r_fill <= r_fill + 1'b1;
      end
      if (w_out_fire) r_head <= r_head + 1'b1;
    end
  end

  // Entry storage: pc written at issue, instruction written at response
  always_ff @(posedge clock) begin
    if (w_req_fire) r_pc[r_alloc[AW-1:0]] <= r_fetch_pc;
    if (w_rsp_take && !redirect_valid && (r_drop == '0))
      r_instr[r_fill[AW-1:0]] <= rsp_data;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: reference model built from queues,
// table-driven backpressure vectors, directed corner sequences, random traffic.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0200;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  logic [31:0] m_fetch;
  int unsigned m_drop;
  logic [31:0] m_live[$];   // pcs in flight whose data will be kept
  ent_t        m_rdy[$];    // entries ready for decode
  logic [31:0] memq[$];     // memory-side pending addresses (live + dropped)

  logic        obs_rv, obs_ov;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch = RPC;
    m_drop  = 0;
    m_live.delete();
    m_rdy.delete();
    memq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'b0, req_valid}, 32'd0);
    chk({tag, "_rsp_ready"}, {31'b0, rsp_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_req_addr"},  req_addr,  RPC);
    chk({tag, "_out_pc"},    out_pc,    32'd0);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
  endtask

  // One clock cycle: drive at negedge, compare against model, advance model at posedge.
  task automatic step(input logic rr, input logic rw, input logic orr,
                      input logic rd, input logic [31:0] rpc);
    logic e_rv, e_ov, rspf, reqf, outf;
    logic [31:0] p;
    @(negedge clock);
    req_ready      = rr;
    rsp_valid      = rw && (memq.size() > 0);
    rsp_data       = rsp_valid ? memdata(memq[0]) : 32'hDEAD_BEEF;
    out_ready      = orr;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #1;
    e_rv = !rd && (m_live.size() + m_rdy.size() + m_drop < DEPTH);
    e_ov = !rd && (m_rdy.size() > 0);
    obs_rv = req_valid; obs_addr = req_addr; obs_ov = out_valid;
    obs_pc = out_pc;    obs_instr = out_instr;
    chk("req_valid", {31'b0, req_valid}, {31'b0, e_rv});
    chk("req_addr",  req_addr, m_fetch);
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
    chk("rsp_ready", {31'b0, rsp_ready}, 32'd1);
    if (e_ov) begin
      chk("out_pc",    out_pc,    m_rdy[0].pc);
      chk("out_instr", out_instr, m_rdy[0].instr);
    end
    if (rsp_valid && m_live.size() == 0 && m_drop == 0) begin
      errors++;
      $display("FAIL protocol: response with nothing outstanding at %0t", $time);
    end
    @(posedge clock);
    rspf = rsp_valid;
    reqf = e_rv && rr;
    outf = e_ov && orr;
    if (rspf) void'(memq.pop_front());
    if (rd) begin
      if (rspf) begin
        if (m_drop > 0) m_drop--;
        else if (m_live.size() > 0) void'(m_live.pop_front());
      end
      m_drop += m_live.size();
      m_live.delete();
      m_rdy.delete();
      m_fetch = rpc & ~32'd3;
    end else begin
      if (outf) void'(m_rdy.pop_front());
      if (rspf) begin
        if (m_drop > 0) m_drop--;
        else begin
          p = m_live.pop_front();
          m_rdy.push_back('{pc: p, instr: memdata(p)});
        end
      end
      if (reqf) begin
        m_live.push_back(m_fetch);
        memq.push_back(m_fetch);
        m_fetch += 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_ready = 0; rsp_valid = 0; rsp_data = '0; out_ready = 0;
    redirect_valid = 0; redirect_pc = '0;
    @(negedge clock);
    #1 check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic rr, rw, orr, rd; logic [31:0] rpc;
    logic e_rv; logic [31:0] e_addr; logic e_ov; logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[9];

  initial begin
    bit seen;
    reset = 1'b1;
    req_ready = 0; rsp_valid = 0; rsp_data = '0; out_ready = 0;
    redirect_valid = 0; redirect_pc = '0;
    model_reset();

    // ---- backpressure: queue fills to DEPTH, one consume reopens fetch ----
    tbl[0] = '{1, 1, 0, 0, 0, 1, 32'h200, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 1, 32'h204, 0, 0};
    tbl[2] = '{1, 1, 0, 0, 0, 1, 32'h208, 1, 32'h200};
    tbl[3] = '{1, 1, 0, 0, 0, 1, 32'h20C, 1, 32'h200};
    tbl[4] = '{1, 1, 0, 0, 0, 0, 32'h210, 1, 32'h200};
    tbl[5] = '{1, 1, 0, 0, 0, 0, 32'h210, 1, 32'h200};
    tbl[6] = '{1, 1, 1, 0, 0, 0, 32'h210, 1, 32'h200};
    tbl[7] = '{1, 1, 0, 0, 0, 1, 32'h210, 1, 32'h204};
    tbl[8] = '{1, 1, 0, 0, 0, 0, 32'h214, 1, 32'h204};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rr, tbl[i].rw, tbl[i].orr, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("t2_req_valid[%0d]", i), {31'b0, obs_rv}, {31'b0, tbl[i].e_rv});
      chk($sformatf("t2_req_addr[%0d]", i),  obs_addr, tbl[i].e_addr);
      chk($sformatf("t2_out_valid[%0d]", i), {31'b0, obs_ov}, {31'b0, tbl[i].e_ov});
      if (tbl[i].e_ov) begin
        chk($sformatf("t2_out_pc[%0d]", i),    obs_pc, tbl[i].e_pc);
        chk($sformatf("t2_out_instr[%0d]", i), obs_instr, memdata(tbl[i].e_pc));
      end
    end

    // ---- streaming: 1-cycle memory, decode always ready, no gaps ----
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 1, 0, 0);
      chk("t1_req_addr", obs_addr, RPC + 32'(4 * k));
      if (k >= 2) begin
        chk("t1_out_valid", {31'b0, obs_ov}, 32'd1);
        chk("t1_out_pc", obs_pc, RPC + 32'(4 * (k - 2)));
      end
    end

    // ---- redirect with 2 outstanding and 1 queued ----
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h1003);
    chk("t3_redir_req_valid", {31'b0, obs_rv}, 32'd0);
    chk("t3_redir_out_valid", {31'b0, obs_ov}, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("t3_req_addr", obs_addr, 32'h1000);
    chk("t3_req_valid", {31'b0, obs_rv}, 32'd1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1, 1, 1, 0, 0);
      if (obs_ov) begin
        seen = 1;
        chk("t3_first_pc", obs_pc, 32'h1000);
        chk("t3_first_instr", obs_instr, memdata(32'h1000));
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL t3_timeout: got no out_valid expected pc 00001000");
    end

    // ---- redirect coincident with the only outstanding response ----
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'h300);
    step(1, 0, 0, 0, 0);
    chk("t4_req_addr", obs_addr, 32'h300);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_out_valid", {31'b0, obs_ov}, 32'd1);
    chk("t4_out_pc", obs_pc, 32'h300);
    chk("t4_out_instr", obs_instr, memdata(32'h300));

    // ---- back-to-back redirects with 3 outstanding ----
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h400);
    step(1, 0, 0, 1, 32'h800);
    step(1, 0, 0, 0, 0);
    chk("t5_req_valid", {31'b0, obs_rv}, 32'd1);
    chk("t5_req_addr", obs_addr, 32'h800);
    step(1, 0, 0, 0, 0);
    chk("t5_credit_full", {31'b0, obs_rv}, 32'd0);
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 1, 0, 0);
      chk("t5_no_400", {31'b0, obs_ov && obs_pc == 32'h400}, 32'd0);
      if (obs_ov && !seen) begin
        seen = 1;
        chk("t5_first_pc", obs_pc, 32'h800);
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL t5_timeout: got no out_valid expected pc 00000800");
    end

    // ---- async reset mid-stream with entries queued ----
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clock);
    req_ready = 0; rsp_valid = 0; out_ready = 0; redirect_valid = 0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    step(1, 0, 1, 0, 0);
    chk("t6_restart_addr", obs_addr, RPC);
    chk("t6_no_stale", {31'b0, obs_ov}, 32'd0);
    for (int k = 0; k < 6; k++) step(1, 1, 1, 0, 0);

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
           $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
